// File: rtl/decode_stage.sv
// RV32I decode stage: registered, valid/ready handshaked, with load-use
// bubble insertion and illegal-instruction flagging.
module decode_stage #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter bit ENABLE_BRANCH    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_op,
  output logic [2:0]  out_encoding,
  output logic        out_reg_write,
  output logic        out_alu_src,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_branch,
  output logic        out_mem_to_reg,
  output logic        out_branch_ne,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic        out_illegal
);

  localparam int CW = (LOAD_USE_BUBBLES > 1) ?
    $clog2(LOAD_USE_BUBBLES + 1) : 1;
  localparam logic [CW-1:0] BUBBLES = CW'(LOAD_USE_BUBBLES);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SRL  = 4'd3;
  localparam logic [3:0] OP_SRA  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  localparam logic [2:0] ENC_R = 3'd0;
  localparam logic [2:0] ENC_I = 3'd1;
  localparam logic [2:0] ENC_S = 3'd2;
  localparam logic [2:0] ENC_B = 3'd3;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [2:0] enc;
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       mem_to_reg;
    logic       branch_ne;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } ctrl_t;

  ctrl_t          dec;
  ctrl_t          entry_q, entry_d;
  logic           entry_valid_q, entry_valid_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4:0]     load_rd_q, load_rd_d;
  logic           load_rd_valid_q, load_rd_valid_d;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       f7_zero, f7_alt;
  logic       is_r, is_i, is_lw, is_sw, is_br;

  assign opcode  = in_instr[6:0];
  assign f3      = in_instr[14:12];
  assign f7      = in_instr[31:25];
  assign f7_zero = (f7 == 7'b0000000);
  assign f7_alt  = (f7 == 7'b0100000);

  assign is_r  = (opcode == 7'b0110011);
  assign is_i  = (opcode == 7'b0010011);
  assign is_lw = (opcode == 7'b0000011) && (f3 == 3'b010);
  assign is_sw = (opcode == 7'b0100011) && (f3 == 3'b010);
  assign is_br = ENABLE_BRANCH && (opcode == 7'b1100011) &&
                 (f3[2:1] == 2'b00);

  function automatic logic [3:0] base_op(input logic [2:0] f);
    logic [3:0] op;
    unique case (f)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    dec     = '0;
    dec.rd  = in_instr[11:7];
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    unique case (1'b1)
      is_r: begin
        dec.enc       = ENC_R;
        dec.reg_write = 1'b1;
        if (f7_zero)
          dec.alu_op = base_op(f3);
        else if (f7_alt && f3 == 3'b000)
          dec.alu_op = OP_SUB;
        else if (f7_alt && f3 == 3'b101)
          dec.alu_op = OP_SRA;
        else
          dec.illegal = 1'b1;
      end
      is_i: begin
        dec.enc       = ENC_I;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = base_op(f3);
        if (f3 == 3'b001 && !f7_zero)
          dec.illegal = 1'b1;
        if (f3 == 3'b101) begin
          if (f7_alt)
            dec.alu_op = OP_SRA;
          else if (!f7_zero)
            dec.illegal = 1'b1;
        end
      end
      is_lw: begin
        dec.enc        = ENC_I;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
      end
      is_sw: begin
        dec.enc       = ENC_S;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      is_br: begin
        dec.enc       = ENC_B;
        dec.alu_op    = OP_SUB;
        dec.branch    = 1'b1;
        dec.branch_ne = f3[0];
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal entries still flow, but must not change architectural state.
    if (dec.illegal) begin
      dec.reg_write  = 1'b0;
      dec.mem_read   = 1'b0;
      dec.mem_write  = 1'b0;
      dec.branch     = 1'b0;
      dec.mem_to_reg = 1'b0;
    end
  end

  logic dependent, stall, depart, accept;

  assign dependent = load_rd_valid_q &&
    ((entry_q.rs1 == load_rd_q) ||
     ((entry_q.enc != ENC_I) && (entry_q.rs2 == load_rd_q)));
  assign stall     = dependent && (cnt_q != '0);
  assign out_valid = entry_valid_q && !stall;
  assign depart    = out_valid && out_ready;
  assign in_ready  = !flush && (!entry_valid_q || depart);
  assign accept    = in_valid && in_ready;

  always_comb begin
    entry_d         = entry_q;
    entry_valid_d   = entry_valid_q;
    cnt_d           = cnt_q;
    load_rd_d       = load_rd_q;
    load_rd_valid_d = load_rd_valid_q;
    if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
    if (depart) begin
      entry_valid_d = 1'b0;
      if (!entry_q.mem_read) begin
        load_rd_valid_d = 1'b0;
      end else if (entry_q.rd != 5'd0) begin
        load_rd_d       = entry_q.rd;
        load_rd_valid_d = 1'b1;
        cnt_d           = BUBBLES;
      end
    end
    if (accept) begin
      entry_valid_d = 1'b1;
      entry_d       = dec;
    end
    if (flush) begin
      entry_valid_d   = 1'b0;
      cnt_d           = '0;
      load_rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q         <= '0;
      entry_valid_q   <= 1'b0;
      cnt_q           <= '0;
      load_rd_q       <= '0;
      load_rd_valid_q <= 1'b0;
    end else begin
      entry_q         <= entry_d;
      entry_valid_q   <= entry_valid_d;
      cnt_q           <= cnt_d;
      load_rd_q       <= load_rd_d;
      load_rd_valid_q <= load_rd_valid_d;
    end
  end

  assign out_alu_op     = entry_q.alu_op;
  assign out_encoding   = entry_q.enc;
  assign out_reg_write  = entry_q.reg_write;
  assign out_alu_src    = entry_q.alu_src;
  assign out_mem_read   = entry_q.mem_read;
  assign out_mem_write  = entry_q.mem_write;
  assign out_branch     = entry_q.branch;
  assign out_mem_to_reg = entry_q.mem_to_reg;
  assign out_branch_ne  = entry_q.branch_ne;
  assign out_rd         = entry_q.rd;
  assign out_rs1        = entry_q.rs1;
  assign out_rs2        = entry_q.rs2;
  assign out_illegal    = entry_q.illegal;

endmodule
